// File: rtl/debug_frame_initiator.sv
// ============================================================================
// debug_frame_initiator
// ----------------------------------------------------------------------------
// Host-side initiator for the OCD debug UART protocol. This block accepts one
// command request and sends it to a byte-wide UART transmitter as a 12-byte
// frame:
//     SYNC0, SYNC1, cmd, addr[31:24..7:0], data[31:24..7:0], chk
// where chk is the XOR of cmd, addr and data. It then hunts for the 8-byte
// reply on the UART receiver:
//     SYNC0, SYNC1, cmd, payload[31:24..7:0], chk
// It checks the reply and returns the command echo, the payload and a status.
//
// Handshakes:
//   - A request is accepted on a rising clk edge where req_valid & req_ready.
//     req_ready is high only in IDLE.
//   - tx_start is a one-cycle pulse. tx_byte stays stable until the UART
//     returns its one-cycle tx_done pulse.
//   - rx_valid is a one-cycle pulse qualifying rx_byte.
//   - rsp_valid is a one-cycle pulse. rsp_cmd, rsp_payload and rsp_error hold
//     their values until the next request is accepted.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_cmd/req_addr/req_data     request fields
//   tx_start/tx_byte/tx_done      UART transmitter interface
//   rx_valid/rx_byte              UART receiver interface
//   rsp_valid/rsp_cmd/rsp_payload/rsp_error
//                                 response; error codes:
//                                   00 ok, 01 checksum bad,
//                                   10 cmd mismatch, 11 timeout
//   busy                          high in every state except IDLE
//   dbg_state                     current FSM state (IDLE encodes as 3'd0)
// ============================================================================
module debug_frame_initiator #(
    parameter logic [7:0]  SYNC0          = 8'h5A,
    parameter logic [7:0]  SYNC1          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rsp_valid,
    output logic [7:0]  rsp_cmd,
    output logic [31:0] rsp_payload,
    output logic [1:0]  rsp_error,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_SEND  = 3'd1,
        S_TX_WAIT  = 3'd2,
        S_RX_SYNC0 = 3'd3,
        S_RX_SYNC1 = 3'd4,
        S_RX_BODY  = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_CMD     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t         r_state;
    logic [3:0]     r_idx;          // index of the TX byte currently in flight
    logic [7:0]     r_cmd;
    logic [31:0]    r_addr;
    logic [31:0]    r_data;
    logic           r_tx_start;
    logic [7:0]     r_tx_byte;
    logic [TW-1:0]  r_to_cnt;
    logic [2:0]     r_rx_cnt;       // number of reply body bytes stored so far
    logic [7:0]     r_rx_xor;       // running checksum over the reply body
    logic [7:0]     r_cap_cmd;
    logic [31:0]    r_cap_payload;
    logic           r_rsp_valid;
    logic [7:0]     r_rsp_cmd;
    logic [31:0]    r_rsp_payload;
    logic [1:0]     r_rsp_error;
    logic           r_req_ready;
    logic           r_busy;

    logic [7:0]     w_tx_chk;
    logic [7:0]     w_next_byte;
    logic           w_rx_last;
    logic           w_chk_bad;
    logic           w_cmd_bad;

    // Returns byte idx of the outgoing frame, built from the latched request.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]  idx,
        input logic [7:0]  cmd,
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [7:0]  chk
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = SYNC0;
            4'd1:    b = SYNC1;
            4'd2:    b = cmd;
            4'd3:    b = addr[31:24];
            4'd4:    b = addr[23:16];
            4'd5:    b = addr[15:8];
            4'd6:    b = addr[7:0];
            4'd7:    b = data[31:24];
            4'd8:    b = data[23:16];
            4'd9:    b = data[15:8];
            4'd10:   b = data[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

    assign w_tx_chk = r_cmd
                    ^ r_addr[31:24] ^ r_addr[23:16] ^ r_addr[15:8] ^ r_addr[7:0]
                    ^ r_data[31:24] ^ r_data[23:16] ^ r_data[15:8] ^ r_data[7:0];

    assign w_next_byte = frame_byte(r_idx + 4'd1, r_cmd, r_addr, r_data, w_tx_chk);

    // The sixth body byte is the reply checksum. It completes the reply even
    // when the timeout expires in the same cycle.
    assign w_rx_last = (r_state == S_RX_BODY) && rx_valid && (r_rx_cnt == 3'd5);
    assign w_chk_bad = (rx_byte != r_rx_xor);
    assign w_cmd_bad = (r_cap_cmd != r_cmd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_idx         <= 4'd0;
            r_cmd         <= 8'd0;
            r_addr        <= 32'd0;
            r_data        <= 32'd0;
            r_tx_start    <= 1'b0;
            r_tx_byte     <= 8'd0;
            r_to_cnt      <= '0;
            r_rx_cnt      <= 3'd0;
            r_rx_xor      <= 8'd0;
            r_cap_cmd     <= 8'd0;
            r_cap_payload <= 32'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_cmd     <= 8'd0;
            r_rsp_payload <= 32'd0;
            r_rsp_error   <= 2'b00;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            // Both are single-cycle pulses unless a branch below sets them.
            r_tx_start  <= 1'b0;
            r_rsp_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cmd         <= req_cmd;
                        r_addr        <= req_addr;
                        r_data        <= req_data;
                        r_idx         <= 4'd0;
                        r_tx_byte     <= SYNC0;
                        r_tx_start    <= 1'b1;
                        r_rsp_cmd     <= 8'd0;
                        r_rsp_payload <= 32'd0;
                        r_rsp_error   <= ERR_OK;
                        r_req_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_TX_SEND;
                    end
                end

                // tx_start is high during this state only.
                S_TX_SEND: begin
                    r_state <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (tx_done) begin
                        if (r_idx == 4'd11) begin
                            r_to_cnt <= '0;
                            r_state  <= S_RX_SYNC0;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_tx_byte  <= w_next_byte;
                            r_tx_start <= 1'b1;
                            r_state    <= S_TX_SEND;
                        end
                    end
                end

                S_RX_SYNC0, S_RX_SYNC1, S_RX_BODY: begin
                    if (r_to_cnt != TO_MAX) begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end

                    if (w_rx_last) begin
                        r_rsp_cmd     <= r_cap_cmd;
                        r_rsp_payload <= r_cap_payload;
                        r_rsp_error   <= w_chk_bad ? ERR_CHK :
                                         w_cmd_bad ? ERR_CMD : ERR_OK;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_to_cnt == TO_LAST) begin
                        // The counter reaches TIMEOUT_CYCLES on this edge.
                        r_rsp_cmd     <= 8'd0;
                        r_rsp_payload <= 32'd0;
                        r_rsp_error   <= ERR_TIMEOUT;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (rx_valid) begin
                        case (r_state)
                            S_RX_SYNC0: begin
                                if (rx_byte == SYNC0) begin
                                    r_state <= S_RX_SYNC1;
                                end
                            end
                            S_RX_SYNC1: begin
                                if (rx_byte == SYNC1) begin
                                    r_rx_cnt <= 3'd0;
                                    r_state  <= S_RX_BODY;
                                end else if (rx_byte != SYNC0) begin
                                    r_state <= S_RX_SYNC0;
                                end
                                // A repeated SYNC0 can still start a valid
                                // header, so the FSM stays in RX_SYNC1.
                            end
                            default: begin
                                if (r_rx_cnt == 3'd0) begin
                                    r_cap_cmd <= rx_byte;
                                    r_rx_xor  <= rx_byte;
                                end else begin
                                    r_cap_payload <= {r_cap_payload[23:0], rx_byte};
                                    r_rx_xor      <= r_rx_xor ^ rx_byte;
                                end
                                r_rx_cnt <= r_rx_cnt + 3'd1;
                            end
                        endcase
                    end
                end

                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign tx_start    = r_tx_start;
    assign tx_byte     = r_tx_byte;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_cmd     = r_rsp_cmd;
    assign rsp_payload = r_rsp_payload;
    assign rsp_error   = r_rsp_error;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_debug_frame_initiator.sv
// Directed bench for debug_frame_initiator (TIMEOUT_CYCLES = 100).
// A small UART transmitter model answers every tx_start with tx_done three
// cycles later and records the transmitted bytes. Expected frame bytes are
// loaded into exp_q from hand-computed vectors:
//   frame A: cmd 03, addr 0000_1000, data DEAD_BEEF, chk 31
//   frame B: cmd A7, addr 0102_0304, data F0E1_D2C3, chk A3
module tb_debug_frame_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rsp_valid;
    logic [7:0]  rsp_cmd;
    logic [31:0] rsp_payload;
    logic [1:0]  rsp_error;
    logic        busy;
    logic [2:0]  dbg_state;

    debug_frame_initiator #(
        .SYNC0          (8'h5A),
        .SYNC1          (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_done     (tx_done),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rsp_valid   (rsp_valid),
        .rsp_cmd     (rsp_cmd),
        .rsp_payload (rsp_payload),
        .rsp_error   (rsp_error),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_got_q[$];
    logic [7:0] rx_q[$];

    int          n_start  = 0;
    int          n_done   = 0;
    int          gap_err  = 0;
    int          frame_n  = 0;
    int unsigned done_cyc = 0;

    int base_start;
    int base_done;
    int base_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- UART transmitter model ----------------
    initial begin : tx_model
        int   cd;
        logic done_prev;
        cd        = 0;
        done_prev = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            done_prev = tx_done;
            tx_done   = 1'b0;
            if (tx_start) n_start++;
            if (!reset_n) begin
                cd      = 0;
                frame_n = 0;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    tx_done = 1'b1;
                    n_done++;
                    if (frame_n == 12) done_cyc = cyc;
                end
            end else if (tx_start) begin
                if (frame_n == 12) frame_n = 0;
                tx_got_q.push_back(tx_byte);
                frame_n++;
                // Every byte after the first must start the cycle after tx_done.
                if (frame_n > 1 && !done_prev) gap_err++;
                cd = 3;
            end else if (done_prev && frame_n > 0 && frame_n < 12) begin
                gap_err++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic [7:0] c, input logic [31:0] a,
                              input logic [31:0] d, input logic [7:0] chk);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        for (int i = 3; i >= 0; i--) exp_q.push_back(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
        exp_q.push_back(chk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_request(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        int guard;
        @(negedge clk);
        base_start = n_start;
        base_done  = n_done;
        base_got   = tx_got_q.size();
        req_valid  = 1'b1;
        req_cmd    = c;
        req_addr   = a;
        req_data   = d;
        guard      = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("accept_to_tx_start", {31'd0, tx_start}, 32'd1);
        check("busy_in_tx", {31'd0, busy}, 32'd1);
        check("ready_in_tx", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic wait_tx_end();
        int guard;
        guard = 0;
        while ((n_done - base_done) < 12 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("tx_done_count", n_done - base_done, 32'd12);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] e;
            logic [7:0] g;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            g = (tx_got_q.size() > base_got + i) ? tx_got_q[base_got + i] : 8'hxx;
            check($sformatf("tx_byte[%0d]", i), {24'd0, g}, {24'd0, e});
        end
        check("tx_start_count", n_start - base_start, 32'd12);
        check("tx_gap_errors", gap_err, 32'd0);
    endtask

    // Sends rx_q, then expects rsp_valid exactly one cycle after the last byte.
    task automatic run_reply(input string tag, input logic [7:0] ecmd,
                             input logic [31:0] epay, input logic [1:0] eerr);
        int guard;
        while (rx_q.size() > 0) send_rx(rx_q.pop_front());
        guard = 0;
        while (!rsp_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_rsp_latency"}, guard, 32'd0);
        check({tag, "_rsp_cmd"}, {24'd0, rsp_cmd}, {24'd0, ecmd});
        check({tag, "_rsp_payload"}, rsp_payload, epay);
        check({tag, "_rsp_error"}, {30'd0, rsp_error}, {30'd0, eerr});
        @(negedge clk);
        check({tag, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic load_reply(input logic [7:0] c, input logic [31:0] p, input logic [7:0] chk);
        rx_q.push_back(8'h5A);
        rx_q.push_back(8'hA5);
        rx_q.push_back(c);
        for (int i = 3; i >= 0; i--) rx_q.push_back(p[i*8 +: 8]);
        rx_q.push_back(chk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        int seen_rsp;
        int seen_tx;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 8'd0;
        req_addr  = 32'd0;
        req_data  = 32'd0;
        rx_valid  = 1'b0;
        rx_byte   = 8'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_error", {30'd0, rsp_error}, 32'd0);
        check("rst_rsp_payload", rsp_payload, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);

        // 1: frame A, clean reply. chk = 03^12^34^56^78 = 0B
        push_frame(8'h03, 32'h0000_1000, 32'hDEAD_BEEF, 8'h31);
        do_request(8'h03, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx_end();
        load_reply(8'h03, 32'h1234_5678, 8'h0B);
        run_reply("good", 8'h03, 32'h1234_5678, 2'b00);

        // 2: frame A again; rx noise and a second request during TX must be
        // ignored; reply is preceded by junk 00 5A before the real header.
        push_frame(8'h03, 32'h0000_1000, 32'hDEAD_BEEF, 8'h31);
        do_request(8'h03, 32'h0000_1000, 32'hDEAD_BEEF);
        send_rx(8'h5A);
        send_rx(8'hA5);
        send_rx(8'h03);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = 8'h55;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        wait_tx_end();
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h5A);
        load_reply(8'h03, 32'h1234_5678, 8'h0B);
        run_reply("junk", 8'h03, 32'h1234_5678, 2'b00);

        // 3: frame B, reply checksum corrupted (correct would be A7)
        push_frame(8'hA7, 32'h0102_0304, 32'hF0E1_D2C3, 8'hA3);
        do_request(8'hA7, 32'h0102_0304, 32'hF0E1_D2C3);
        wait_tx_end();
        load_reply(8'hA7, 32'h0000_0000, 8'h00);
        run_reply("chk_bad", 8'hA7, 32'h0000_0000, 2'b01);

        // 4: frame B, echo cmd 04 with a good checksum (04^12^34^56^78 = 0C)
        push_frame(8'hA7, 32'h0102_0304, 32'hF0E1_D2C3, 8'hA3);
        do_request(8'hA7, 32'h0102_0304, 32'hF0E1_D2C3);
        wait_tx_end();
        load_reply(8'h04, 32'h1234_5678, 8'h0C);
        run_reply("cmd_bad", 8'h04, 32'h1234_5678, 2'b10);

        // 5: frame A, echo 04 with bad checksum: checksum error has priority
        push_frame(8'h03, 32'h0000_1000, 32'hDEAD_BEEF, 8'h31);
        do_request(8'h03, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx_end();
        load_reply(8'h04, 32'h1234_5678, 8'h0B);
        run_reply("both_bad", 8'h04, 32'h1234_5678, 2'b01);

        // 6: frame A, no reply: timeout 100 cycles after RX entry
        push_frame(8'h03, 32'h0000_1000, 32'hDEAD_BEEF, 8'h31);
        do_request(8'h03, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_tx_end();
        guard = 0;
        while (!rsp_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("timeout_seen", {31'd0, rsp_valid}, 32'd1);
        check("timeout_latency", cyc - done_cyc - 1, 32'd100);
        check("timeout_error", {30'd0, rsp_error}, 32'd3);
        check("timeout_payload", rsp_payload, 32'd0);
        @(negedge clk);
        check("timeout_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("timeout_ready_back", {31'd0, req_ready}, 32'd1);

        // 7: reset while byte 5 of frame B is in flight
        do_request(8'hA7, 32'h0102_0304, 32'hF0E1_D2C3);
        guard = 0;
        while ((n_start - base_start) < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_byte5", n_start - base_start, 32'd5);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_tx_start", {31'd0, tx_start}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        seen_rsp = 0;
        seen_tx  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
            if (tx_start) seen_tx++;
        end
        check("abort_no_rsp", seen_rsp, 32'd0);
        check("abort_no_tx", seen_tx, 32'd0);
        check("abort_ready_idle", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
